// File: rtl/inst_fetch_pkg.sv
// Shared fetch definitions: state codes, instruction
// field positions and PC arithmetic helpers.
package inst_fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_REQ   = 2'd1;
  localparam fetch_state_t ST_ISSUE = 2'd2;
  localparam fetch_state_t ST_WAIT  = 2'd3;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int TGT_HI = 25;
  localparam int FN_HI  = 5;

  localparam logic [31:0] PC_INC = 32'h4;

  function automatic logic [31:0] sext_x4(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_next_pc.sv
// Next fetch address: jump, taken branch or
// sequential, all modulo 2^32.
module next_pc
  import inst_fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_target,
  input  logic [15:0] i_imm,
  input  logic        i_jump,
  input  logic        i_br_taken,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_pc_plus4;
  logic        w_br_only;

  assign w_pc_plus4 = i_pc + PC_INC;
  // jump has priority over a taken branch
  assign w_br_only  = i_br_taken & ~i_jump;

  always_comb begin
    o_next_pc = w_pc_plus4;
    unique case (1'b1)
      i_jump: o_next_pc =
        {w_pc_plus4[31:28], i_target, 2'b00};
      w_br_only: o_next_pc =
        w_pc_plus4 + sext_x4(i_imm);
      default: o_next_pc = w_pc_plus4;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Multi-cycle instruction fetch: IDLE/REQ/ISSUE/WAIT
// with sticky branch/jump redirect resolution.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          RESOLVE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [25:0] target,
  output logic        inst_valid,
  input  logic        branch,
  input  logic        branch_cond,
  input  logic        jump,
  output logic [31:0] pc
);

  localparam int CW = $clog2(RESOLVE_CYCLES + 1);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst;
  logic [CW-1:0] r_cnt;
  logic         r_jump;
  logic         r_br;

  logic         w_jump_seen;
  logic         w_br_seen;
  logic [31:0]  w_next_pc;

  // include the current WAIT cycle's sample
  assign w_jump_seen = r_jump | jump;
  assign w_br_seen   = r_br | (branch & branch_cond);

  next_pc u_next_pc (
    .i_pc       (r_pc),
    .i_target   (r_inst[TGT_HI:0]),
    .i_imm      (r_inst[IMM_HI:0]),
    .i_jump     (w_jump_seen),
    .i_br_taken (w_br_seen),
    .o_next_pc  (w_next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
      r_cnt   <= '0;
      r_jump  <= 1'b0;
      r_br    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (!hold) r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (imem_ready) begin
            r_inst  <= imem_rdata;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= CW'(RESOLVE_CYCLES - 1);
          r_jump  <= 1'b0;
          r_br    <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_pc    <= w_next_pc;
            r_jump  <= 1'b0;
            r_br    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt  <= r_cnt - CW'(1);
            r_jump <= w_jump_seen;
            r_br   <= w_br_seen;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req   = (r_state == ST_REQ);
  assign imem_addr  = r_pc;
  assign inst_valid = (r_state == ST_ISSUE);
  assign pc         = r_pc;

  assign op     = r_inst[OP_HI:OP_LO];
  assign rs     = r_inst[RS_HI:RS_LO];
  assign rt     = r_inst[RT_HI:RT_LO];
  assign rd     = r_inst[RD_HI:RD_LO];
  assign imm    = r_inst[IMM_HI:0];
  assign target = r_inst[TGT_HI:0];
  assign funct  = r_inst[FN_HI:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: two instances
// (RESET_PC 0 and 0x1000_0040) driven in lockstep.
module tb_inst_fetch;

  localparam int RC = 2;
  localparam logic [31:0] RPC1 = 32'h1000_0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch = 1'b0;
  logic        branch_cond = 1'b0;
  logic        jump = 1'b0;

  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, pc;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  logic        imem_req_j, inst_valid_j;
  logic [31:0] imem_addr_j, pc_j;
  logic [5:0]  op_j, funct_j;
  logic [4:0]  rs_j, rt_j, rd_j;
  logic [15:0] imm_j;
  logic [25:0] target_j;

  int cmp = 0;
  int mis = 0;
  logic [31:0] m_pc0, m_pc1;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0), .RESOLVE_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .target(target), .inst_valid(inst_valid),
    .branch(branch), .branch_cond(branch_cond),
    .jump(jump), .pc(pc)
  );

  inst_fetch #(.RESET_PC(RPC1), .RESOLVE_CYCLES(RC)) dut_j (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .imem_req(imem_req_j), .imem_addr(imem_addr_j),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .op(op_j), .funct(funct_j), .rs(rs_j), .rt(rt_j),
    .rd(rd_j), .imm(imm_j), .target(target_j),
    .inst_valid(inst_valid_j), .branch(branch),
    .branch_cond(branch_cond), .jump(jump), .pc(pc_j)
  );

  function automatic logic [31:0] ref_next(
    input logic [31:0] p, input logic [31:0] ins,
    input bit taken, input bit jmp
  );
    logic signed [15:0] s;
    logic [31:0] seq;
    s = ins[15:0];
    seq = p + 32'd4;
    if (jmp)
      return (seq & 32'hF000_0000) | (32'(ins[25:0]) * 4);
    else if (taken)
      return seq + 32'(int'(s) * 4);
    return seq;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    m_pc0 = 32'h0;
    m_pc1 = RPC1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic fetch(
    input logic [31:0] ins, input int dly,
    input logic [RC-1:0] br, bc, jp,
    output logic [31:0] a0, a1, e0, e1, fobs, tobs,
    output bit stable, vok, fstab, tmo,
    output time treq
  );
    int n;
    stable = 1; vok = 1; fstab = 1; tmo = 0;
    a0 = '0; a1 = '0; fobs = '0; tobs = '0; treq = 0;
    e0 = m_pc0; e1 = m_pc1;
    n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (imem_req !== 1'b1) begin
      tmo = 1;
      return;
    end
    treq = $time;
    a0 = imem_addr;
    a1 = imem_addr_j;
    repeat (dly) begin
      @(posedge clk); #1;
      if (imem_req !== 1'b1 || imem_addr !== a0 ||
          inst_valid !== 1'b0) stable = 0;
    end
    imem_rdata = ins;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    if (inst_valid !== 1'b1) vok = 0;
    fobs = {op, rs, rt, rd, imm[10:0]};
    tobs = {funct, target};
    @(posedge clk); #1;
    for (int i = 0; i < RC; i++) begin
      if (inst_valid !== 1'b0) vok = 0;
      if ({op, rs, rt, rd, imm[10:0]} !== fobs) fstab = 0;
      branch = br[i];
      branch_cond = bc[i];
      jump = jp[i];
      @(posedge clk); #1;
    end
    branch = 1'b0;
    branch_cond = 1'b0;
    jump = 1'b0;
    m_pc0 = ref_next(m_pc0, ins, |(br & bc), |jp);
    m_pc1 = ref_next(m_pc1, ins, |(br & bc), |jp);
  endtask

  logic [31:0] a0, a1, e0, e1, fo, to;
  bit st, vk, fs, tm;
  time tq, tprev;

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    cmp++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      mis++;
      $display("FAIL rst_ctrl got req=%b vld=%b want 0 0",
               imem_req, inst_valid);
    end
    cmp++;
    if (pc !== 32'h0 || pc_j !== RPC1) begin
      mis++;
      $display("FAIL rst_pc got %h %h want 0 %h",
               pc, pc_j, RPC1);
    end
    cmp++;
    if ({op, rs, rt, rd, imm[10:0]} !== 32'h0 ||
        target !== 26'h0 || funct !== 6'h0) begin
      mis++;
      $display("FAIL rst_fields got op=%h tgt=%h want 0",
               op, target);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] want;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fetch($urandom, 0, '0, '0, '0,
            a0, a1, e0, e1, fo, to, st, vk, fs, tm, tq);
      want = 32'(k * 4);
      cmp++;
      if (tm || a0 !== want) begin
        mis++;
        $display("FAIL seq_addr%0d got %h want %h (tmo=%0b)",
                 k, a0, want, tm);
      end
      if (k > 0) begin
        cmp++;
        if (tq - tprev != 50) begin
          mis++;
          $display("FAIL seq_period%0d got %0t want 50",
                   k, tq - tprev);
        end
      end
      tprev = tq;
    end
  endtask

  task automatic test_delayed_ready();
    logic [31:0] ins;
    ins = $urandom;
    fetch(ins, 3, '0, '0, '0,
          a0, a1, e0, e1, fo, to, st, vk, fs, tm, tq);
    cmp++;
    if (tm || !st || a0 !== e0) begin
      mis++;
      $display("FAIL dly_req got addr=%h stable=%0b want %h 1",
               a0, st, e0);
    end
    cmp++;
    if (!vk) begin
      mis++;
      $display("FAIL dly_valid got bad pulse want 1-cycle");
    end
    cmp++;
    if (fo !== ins || to !== {ins[5:0], ins[25:0]} || !fs) begin
      mis++;
      $display("FAIL dly_fields got %h %h want %h", fo, to, ins);
    end
  endtask

  task automatic test_branch();
    logic [31:0] seq [5];
    logic [31:0] want [5];
    logic [RC-1:0] bcs [5];
    logic [RC-1:0] jps [5];
    seq[0] = {6'h02, 26'h40};  jps[0] = 2'b01; bcs[0] = 2'b00;
    seq[1] = {6'h04, 5'd1, 5'd0, 16'hFFFE};
    jps[1] = 2'b00; bcs[1] = 2'b01;
    seq[2] = {6'h02, 26'h40};  jps[2] = 2'b10; bcs[2] = 2'b00;
    seq[3] = {6'h04, 5'd1, 5'd0, 16'hFFFE};
    jps[3] = 2'b00; bcs[3] = 2'b00;
    seq[4] = 32'h0;            jps[4] = 2'b00; bcs[4] = 2'b00;
    want[0] = 32'h0;   want[1] = 32'h100; want[2] = 32'h0FC;
    want[3] = 32'h100; want[4] = 32'h104;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      fetch(seq[k], 0, 2'b11, bcs[k], jps[k],
            a0, a1, e0, e1, fo, to, st, vk, fs, tm, tq);
      cmp++;
      if (tm || a0 !== want[k] || a1 !== e1) begin
        mis++;
        $display("FAIL br_addr%0d got %h/%h want %h/%h",
                 k, a0, a1, want[k], e1);
      end
    end
  endtask

  task automatic test_jump();
    do_reset();
    fetch({6'h02, 26'h0000123}, 0, 2'b01, 2'b01, 2'b01,
          a0, a1, e0, e1, fo, to, st, vk, fs, tm, tq);
    cmp++;
    if (tm || a1 !== RPC1) begin
      mis++;
      $display("FAIL jmp_start got %h want %h", a1, RPC1);
    end
    fetch(32'h0, 0, '0, '0, '0,
          a0, a1, e0, e1, fo, to, st, vk, fs, tm, tq);
    cmp++;
    if (tm || a1 !== 32'h1000_048C || a0 !== 32'h48C) begin
      mis++;
      $display("FAIL jmp_addr got %h/%h want 1000048c/48c",
               a1, a0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch({6'h04, 10'h0, 16'hFFFE}, 0, 2'b10, 2'b10, '0,
          a0, a1, e0, e1, fo, to, st, vk, fs, tm, tq);
    fetch(32'h0, 0, '0, '0, '0,
          a0, a1, e0, e1, fo, to, st, vk, fs, tm, tq);
    cmp++;
    if (tm || a0 !== 32'hFFFF_FFFC) begin
      mis++;
      $display("FAIL wrap_neg got %h want fffffffc", a0);
    end
    fetch(32'h0, 0, '0, '0, '0,
          a0, a1, e0, e1, fo, to, st, vk, fs, tm, tq);
    cmp++;
    if (tm || a0 !== 32'h0) begin
      mis++;
      $display("FAIL wrap_zero got %h want 0", a0);
    end
  endtask

  task automatic test_reset_mid_req();
    int n;
    do_reset();
    fetch({6'h02, 26'h8}, 0, '0, '0, 2'b10,
          a0, a1, e0, e1, fo, to, st, vk, fs, tm, tq);
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      mis++;
      $display("FAIL rmid_pre got req=%b addr=%h want 1 20",
               imem_req, imem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if (imem_req !== 1'b0 || pc !== 32'h0) begin
      mis++;
      $display("FAIL rmid_async got req=%b pc=%h want 0 0",
               imem_req, pc);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_pc0 = 32'h0;
    m_pc1 = RPC1;
    fetch(32'h0, 0, '0, '0, '0,
          a0, a1, e0, e1, fo, to, st, vk, fs, tm, tq);
    cmp++;
    if (tm || a0 !== 32'h0 || a1 !== RPC1) begin
      mis++;
      $display("FAIL rmid_first got %h/%h want 0/%h",
               a0, a1, RPC1);
    end
  endtask

  task automatic test_hold();
    int bad;
    hold = 1'b1;
    do_reset();
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (imem_req !== 1'b0) bad++;
    end
    cmp++;
    if (bad != 0) begin
      mis++;
      $display("FAIL hold_block got %0d req cycles want 0", bad);
    end
    hold = 1'b0;
    @(posedge clk); #1;
    cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      mis++;
      $display("FAIL hold_release got req=%b addr=%h want 1 0",
               imem_req, imem_addr);
    end
    fetch(32'h0, 0, '0, '0, '0,
          a0, a1, e0, e1, fo, to, st, vk, fs, tm, tq);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [RC-1:0] br, bc, jp;
    int d;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      ins = $urandom;
      d = $urandom_range(0, 2);
      br = RC'($urandom_range(0, 3));
      bc = RC'($urandom_range(0, 3));
      jp = ($urandom_range(0, 3) == 0) ?
           RC'($urandom_range(1, 3)) : '0;
      fetch(ins, d, br, bc, jp,
            a0, a1, e0, e1, fo, to, st, vk, fs, tm, tq);
      cmp++;
      if (tm || a0 !== e0 || a1 !== e1) begin
        mis++;
        $display("FAIL rnd_addr%0d got %h/%h want %h/%h",
                 k, a0, a1, e0, e1);
      end
      cmp++;
      if (fo !== ins || to !== {ins[5:0], ins[25:0]} ||
          !fs || !vk || !st) begin
        mis++;
        $display("FAIL rnd_fetch%0d got %h v=%0b s=%0b want %h",
                 k, fo, vk, st, ins);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_delayed_ready();
    test_branch();
    test_jump();
    test_wrap();
    test_reset_mid_req();
    test_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter RESOLVE_CYCLES, default 2: cycles spent in WAIT for registered control outcomes (Control output latency 1, datapath compare 1).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 hold  input  1  when high, no new fetch is launched from IDLE.
REQ-006 imem_req  output  1  instruction memory request; held high until accepted.
REQ-007 imem_addr  output  32  word-aligned fetch address; equals pc while imem_req is high.
REQ-008 imem_ready  input  1  memory accepts the request and imem_rdata is valid in the same cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 op, funct  output  6 each  instruction fields [31:26] and [5:0], feeding the control decoder.
REQ-011 rs, rt, rd  output  5 each  fields [25:21], [20:16], [15:11].
REQ-012 imm  output  16  field [15:0]; target  output  26  field [25:0].
REQ-013 inst_valid  output  1  one-cycle pulse: fields hold a newly fetched instruction.
REQ-014 branch, branch_cond, jump  input  1 each  control-decoder branch/jump flags and datapath compare result (rs > 0).
REQ-015 pc  output  32  address of the instruction currently held.

Function
REQ-016 FSM states: IDLE, REQ, ISSUE, WAIT; encoding is implementation choice.
REQ-017 IDLE -> REQ when hold is low; remains IDLE while hold is high.
REQ-018 REQ: imem_req=1, imem_addr=pc; on imem_ready latch imem_rdata into instruction register, -> ISSUE.
REQ-019 ISSUE: inst_valid=1 for exactly one cycle; -> WAIT; wait counter loaded with RESOLVE_CYCLES-1.
REQ-020 WAIT: counter decrements each cycle; branch, branch_cond and jump are sampled every WAIT cycle and redirect is sticky until leaving WAIT.
REQ-021 On leaving WAIT (counter==0) pc updates and state -> IDLE:
  - jump seen: pc <= {pc_plus4[31:28], target, 2'b00}
  - else branch&&branch_cond seen: pc <= pc_plus4 + {sext(imm), 2'b00}
  - else pc <= pc + 4.
REQ-022 jump and taken branch in the same window: jump wins.
REQ-023 Address arithmetic is 32-bit modulo 2^32; pc 32'hFFFF_FFFC + 4 wraps to 0.
REQ-024 Field outputs remain stable from ISSUE until the next imem_ready acceptance.
REQ-025 imem_req is never dropped in REQ before imem_ready; hold has no effect outside IDLE.
REQ-026 Latency from imem_ready to inst_valid is exactly 1 cycle; fetch-to-fetch period is RESOLVE_CYCLES + 3 cycles with zero memory wait.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, pc=RESET_PC, instruction register=0, imem_req=0, inst_valid=0, redirect flags and counter=0.
REQ-028 Reset mid-REQ or mid-WAIT discards the pending fetch/redirect; first request after release uses RESET_PC.

Structure
REQ-029 Shared package holds FSM state typedef, opcode field positions, and the 32'h4 PC increment constant shared with the control decoder opcodes.
REQ-030 One sub-module, next_pc, computes the redirect/sequential address combinationally; everything else is in inst_fetch.

Verification
REQ-031 Reset release, hold=0, imem_ready=1 always -> imem_addr sequence 0,4,8 at a fetch period of RESOLVE_CYCLES+3=5 cycles.
REQ-032 imem_ready delayed 3 cycles -> imem_req and imem_addr stable throughout, inst_valid exactly 1 cycle after acceptance.
REQ-033 pc=0x100, imm=16'hFFFE, branch=1, branch_cond=1 in WAIT -> next imem_addr=0x0FC; branch_cond=0 -> 0x104.
REQ-034 pc=0x1000_0040, target=26'h0000123, jump=1 together with taken branch -> next imem_addr=0x1000_048C.
REQ-035 rst_n asserted during REQ at pc=0x20 -> imem_req falls immediately; after release first imem_addr=RESET_PC.
REQ-036 hold=1 in IDLE for 10 cycles -> no imem_req; hold=0 -> request issued the next cycle at unchanged pc.
